// File: rtl/rv32m_divider_pkg.sv
// Shared types for the RV32M iterative divider: operation/state enums,
// the working-register pair and the single restoring shift-subtract step.
package rv32m_divider_pkg;

  localparam int XLEN_W    = 32;
  localparam int DIV_ITERS = 32;

  typedef logic [XLEN_W-1:0] word_t;

  localparam word_t INT_MIN = {1'b1, {(XLEN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } divop_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } divstate_t;

  // Partial remainder carries one guard bit so the trial subtraction's sign
  // is always visible in its MSB.
  typedef struct packed {
    logic [XLEN_W:0] rem;
    word_t           quo;
  } div_acc_t;

  function automatic div_acc_t div_step(input div_acc_t acc, input word_t dvs);
    logic [XLEN_W:0] sh;
    logic [XLEN_W:0] diff;
    div_acc_t        nxt;
    sh       = {acc.rem[XLEN_W-1:0], acc.quo[XLEN_W-1]};
    diff     = sh - {1'b0, dvs};
    nxt.quo  = {acc.quo[XLEN_W-2:0], ~diff[XLEN_W]};
    nxt.rem  = diff[XLEN_W] ? sh : diff;
    return nxt;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Handshake bundle between the execute stage and the divider; `div` is the
// unit's view, `tb` the requester/consumer view.
interface divider_if;
  import rv32m_divider_pkg::*;

  logic   in_valid;
  logic   in_ready;
  divop_t div_op;
  word_t  dividend;
  word_t  divisor;
  logic   kill;
  logic   out_valid;
  logic   out_ready;
  word_t  result;
  logic   busy;

  modport div (
    input  in_valid, div_op, dividend, divisor, kill, out_ready,
    output in_ready, out_valid, result, busy
  );

  modport tb (
    output in_valid, div_op, dividend, divisor, kill, out_ready,
    input  in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/rv32m_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU (34-cycle fixed path).
// Defining DIVIDER_EARLY_OUT_EN finishes trivial cases on the accept edge.
module rv32m_divider
  import rv32m_divider_pkg::*;
#(
  parameter int XLEN = XLEN_W
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  divop_t          div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  divstate_t  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  divop_t     op_q, op_d;
  logic       neg_q_q, neg_q_d;
  logic       neg_r_q, neg_r_d;
  logic       dvz_q, dvz_d;
  word_t      result_q, result_d;

  div_acc_t   acc_q;
  word_t      dvs_q;

  logic       accept, load, step;
  logic       signed_op, a_neg, b_neg, dvz_in;
  word_t      a_mag, b_mag, quo_fix, rem_fix;

  always_comb begin
    signed_op = ~div_op[0];
    a_neg     = signed_op & dividend[XLEN_W-1];
    b_neg     = signed_op & divisor[XLEN_W-1];
    a_mag     = a_neg ? word_t'(-dividend) : dividend;
    b_mag     = b_neg ? word_t'(-divisor) : divisor;
    dvz_in    = (divisor == '0);
    accept    = in_valid && in_ready && !kill;
  end

`ifdef DIVIDER_EARLY_OUT_EN
  logic  ovf_in, early_hit;
  word_t early_quo, early_rem;

  always_comb begin
    ovf_in    = signed_op && (dividend == INT_MIN) && (divisor == '1);
    early_hit = dvz_in || ovf_in || (a_mag < b_mag);
    early_quo = dvz_in ? '1 : (ovf_in ? INT_MIN : '0);
    early_rem = ovf_in ? '0 : dividend;
  end
`endif

  // Divide-by-zero leaves the quotient all ones regardless of sign.
  always_comb begin
    quo_fix = dvz_q ? '1 : (neg_q_q ? word_t'(-acc_q.quo) : acc_q.quo);
    rem_fix = neg_r_q ? word_t'(-acc_q.rem[XLEN_W-1:0]) : acc_q.rem[XLEN_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dvz_d    = dvz_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = div_op;
          neg_q_d = signed_op && (dividend[XLEN_W-1] != divisor[XLEN_W-1]);
          neg_r_d = a_neg;
          dvz_d   = dvz_in;
          cnt_d   = '0;
          load    = 1'b1;
          state_d = ITER;
`ifdef DIVIDER_EARLY_OUT_EN
          if (early_hit) begin
            state_d  = DONE;
            result_d = div_op[1] ? early_rem : early_quo;
          end
`endif
        end
      end
      ITER: begin
        step  = 1'b1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        result_d = op_q[1] ? rem_fix : quo_fix;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (kill) begin
      state_d  = IDLE;
      cnt_d    = cnt_q;
      result_d = result_q;
      load     = 1'b0;
      step     = 1'b0;
    end
  end

  // Control and visible result: async reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= DIV;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dvz_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dvz_q    <= dvz_d;
      result_q <= result_d;
    end
  end

  // Working registers: only meaningful between load and FIX, so no reset
  always_ff @(posedge CLK) begin
    if (load) begin
      acc_q <= '{rem: '0, quo: a_mag};
      dvs_q <= b_mag;
    end else if (step) begin
      acc_q <= div_step(acc_q, dvs_q);
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_rv32m_divider.sv
// Self-checking bench for rv32m_divider: directed cases, handshake/kill/reset
// scenarios and a randomized regression against an arithmetic reference.
module tb_rv32m_divider;
  import rv32m_divider_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  divider_if dif();

  rv32m_divider #(.XLEN(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (dif.in_valid),
    .in_ready  (dif.in_ready),
    .div_op    (dif.div_op),
    .dividend  (dif.dividend),
    .divisor   (dif.divisor),
    .kill      (dif.kill),
    .out_valid (dif.out_valid),
    .out_ready (dif.out_ready),
    .result    (dif.result),
    .busy      (dif.busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    divop_t op;
    word_t  a;
    word_t  b;
    word_t  exp;
  } vec_t;

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic word_t ref_res(divop_t op, word_t a, word_t b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      DIV:     ref_res = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : word_t'($signed(a) / $signed(b)));
      DIVU:    ref_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:     ref_res = (b == 0) ? a : (ovf ? 32'h0 : word_t'($signed(a) % $signed(b)));
      default: ref_res = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_early(divop_t op, word_t a, word_t b);
    bit    s;
    word_t ma, mb;
    s  = (op == DIV) || (op == REM);
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (b == 0) return 1'b1;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return ma < mb;
  endfunction

  // Cycles between the accept sample and the first out_valid sample.
  function automatic int exp_lat(divop_t op, word_t a, word_t b);
`ifdef DIVIDER_EARLY_OUT_EN
    return ref_early(op, a, b) ? 0 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic run_op(input divop_t op, input word_t a, input word_t b,
                        output word_t res, output int lat, output bit hs_bad);
    hs_bad       = 1'b0;
    dif.div_op   = op;
    dif.dividend = a;
    dif.divisor  = b;
    dif.in_valid = 1'b1;
    @(posedge CLK); #1;
    dif.in_valid = 1'b0;
    lat = 0;
    while (!dif.out_valid && lat < 100) begin
      if (dif.in_ready || !dif.busy) hs_bad = 1'b1;
      @(posedge CLK); #1;
      lat++;
    end
    res = dif.result;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #3;
    checks++; if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", dif.in_ready); end
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", dif.out_valid); end
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", dif.busy); end
    checks++; if (dif.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", dif.result); end
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (dif.in_ready !== 1'b1 || dif.busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got ready=%b busy=%b want 1/0", dif.in_ready, dif.busy);
    end
  endtask

  task automatic test_unsigned();
    vec_t  v[4];
    word_t r;
    int    lat;
    bit    hs;
    v[0] = '{DIVU, 32'd100, 32'd7, 32'd14};
    v[1] = '{REMU, 32'd100, 32'd7, 32'd2};
    v[2] = '{DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    v[3] = '{REMU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, r, lat, hs);
      checks++; if (r !== v[i].exp) begin errors++; $display("FAIL unsigned[%0d] result got %h want %h", i, r, v[i].exp); end
      checks++; if (lat !== exp_lat(v[i].op, v[i].a, v[i].b)) begin
        errors++; $display("FAIL unsigned[%0d] latency got %0d want %0d", i, lat, exp_lat(v[i].op, v[i].a, v[i].b));
      end
      checks++; if (hs !== 1'b0) begin errors++; $display("FAIL unsigned[%0d] busy_ready got %b want 0", i, hs); end
    end
  endtask

  task automatic test_signed();
    vec_t  v[5];
    word_t r;
    int    lat;
    bit    hs;
    v[0] = '{DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    v[1] = '{REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    v[2] = '{REM, 32'd7, 32'hFFFF_FFFE, 32'd1};
    v[3] = '{DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    v[4] = '{DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, r, lat, hs);
      checks++; if (r !== v[i].exp) begin errors++; $display("FAIL signed[%0d] result got %h want %h", i, r, v[i].exp); end
      checks++; if (lat !== exp_lat(v[i].op, v[i].a, v[i].b)) begin
        errors++; $display("FAIL signed[%0d] latency got %0d want %0d", i, lat, exp_lat(v[i].op, v[i].a, v[i].b));
      end
    end
  endtask

  task automatic test_special();
    vec_t  v[8];
    word_t r;
    int    lat;
    bit    hs;
    v[0] = '{DIV,  32'h0000_0055, 32'h0, 32'hFFFF_FFFF};
    v[1] = '{DIV,  32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFFF};
    v[2] = '{REMU, 32'h0000_1234, 32'h0, 32'h0000_1234};
    v[3] = '{REM,  32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0};
    v[4] = '{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[5] = '{REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    v[6] = '{DIVU, 32'd3, 32'd10, 32'd0};
    v[7] = '{REM,  32'd3, 32'hFFFF_FFF6, 32'd3};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, r, lat, hs);
      checks++; if (r !== v[i].exp) begin errors++; $display("FAIL special[%0d] result got %h want %h", i, r, v[i].exp); end
      checks++; if (lat !== exp_lat(v[i].op, v[i].a, v[i].b)) begin
        errors++; $display("FAIL special[%0d] latency got %0d want %0d", i, lat, exp_lat(v[i].op, v[i].a, v[i].b));
      end
    end
  endtask

  task automatic test_hold();
    word_t r0;
    int    n;
    bit    bad;
    dif.out_ready = 1'b0;
    dif.div_op    = DIVU;
    dif.dividend  = 32'd1000;
    dif.divisor   = 32'd10;
    dif.in_valid  = 1'b1;
    @(posedge CLK); #1;
    dif.in_valid = 1'b0;
    n = 0;
    while (!dif.out_valid && n < 100) begin @(posedge CLK); #1; n++; end
    checks++; if (dif.out_valid !== 1'b1) begin errors++; $display("FAIL hold_reach_done got %b want 1", dif.out_valid); end
    r0  = dif.result;
    bad = 1'b0;
    dif.div_op   = DIVU;
    dif.dividend = 32'd50;
    dif.divisor  = 32'd5;
    dif.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (dif.out_valid !== 1'b1 || dif.result !== r0 || dif.in_ready !== 1'b0) bad = 1'b1;
    end
    dif.in_valid = 1'b0;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL hold_stable got changed=%b want 0", bad); end
    checks++; if (r0 !== 32'd100) begin errors++; $display("FAIL hold_result got %h want %h", r0, 32'd100); end
    dif.out_ready = 1'b1;
    @(posedge CLK); #1;
    checks++; if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release got ready=%b valid=%b want 1/0", dif.in_ready, dif.out_valid);
    end
    @(posedge CLK); #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL hold_no_accept got busy=%b want 0", dif.busy); end
  endtask

  task automatic test_kill();
    bit    saw;
    word_t r;
    int    lat;
    bit    hs;
    saw          = 1'b0;
    dif.div_op   = DIVU;
    dif.dividend = 32'hFFFF_0000;
    dif.divisor  = 32'd3;
    dif.in_valid = 1'b1;
    @(posedge CLK); #1;
    dif.in_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (dif.out_valid) saw = 1'b1;
      @(posedge CLK); #1;
    end
    dif.kill = 1'b1;
    @(posedge CLK); #1;
    dif.kill = 1'b0;
    checks++; if (dif.in_ready !== 1'b1 || dif.busy !== 1'b0 || dif.out_valid !== 1'b0) begin
      errors++; $display("FAIL kill_idle got ready=%b busy=%b valid=%b want 1/0/0", dif.in_ready, dif.busy, dif.out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      if (dif.out_valid) saw = 1'b1;
      @(posedge CLK); #1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL kill_no_valid got %b want 0", saw); end
    dif.div_op   = DIVU;
    dif.dividend = 32'd77;
    dif.divisor  = 32'd7;
    dif.in_valid = 1'b1;
    dif.kill     = 1'b1;
    @(posedge CLK); #1;
    dif.in_valid = 1'b0;
    dif.kill     = 1'b0;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL kill_blocks_accept got busy=%b want 0", dif.busy); end
    run_op(DIVU, 32'd9, 32'd3, r, lat, hs);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL kill_then_divu got %h want %h", r, 32'd3); end
  endtask

  task automatic test_rst();
    word_t r;
    int    lat;
    bit    hs;
    dif.div_op   = DIVU;
    dif.dividend = 32'd12345;
    dif.divisor  = 32'd7;
    dif.in_valid = 1'b1;
    @(posedge CLK); #1;
    dif.in_valid = 1'b0;
    repeat (10) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    checks++; if (dif.in_ready !== 1'b1 || dif.busy !== 1'b0 || dif.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async_ctrl got ready=%b busy=%b valid=%b want 1/0/0", dif.in_ready, dif.busy, dif.out_valid);
    end
    checks++; if (dif.result !== 32'h0) begin errors++; $display("FAIL rst_async_result got %h want 00000000", dif.result); end
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    run_op(DIVU, 32'd12345, 32'd7, r, lat, hs);
    checks++; if (r !== 32'd1763) begin errors++; $display("FAIL rst_recover got %h want %h", r, 32'd1763); end
  endtask

  task automatic test_random();
    divop_t op;
    word_t  a, b, r;
    int     lat;
    bit     hs;
    for (int n = 0; n < 1200; n++) begin
      op = divop_t'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 15);
        4: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: ;
      endcase
      run_op(op, a, b, r, lat, hs);
      checks++; if (r !== ref_res(op, a, b)) begin
        errors++; $display("FAIL random[%0d] op=%0d a=%h b=%h result got %h want %h", n, op, a, b, r, ref_res(op, a, b));
      end
      checks++; if (lat !== exp_lat(op, a, b)) begin
        errors++; $display("FAIL random[%0d] latency got %0d want %0d", n, lat, exp_lat(op, a, b));
      end
    end
  endtask

  initial begin
    RST           = 1'b1;
    dif.in_valid  = 1'b0;
    dif.kill      = 1'b0;
    dif.out_ready = 1'b1;
    dif.div_op    = DIVU;
    dif.dividend  = '0;
    dif.divisor   = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_hold();
    test_kill();
    test_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
